// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the async FIFO: pops the show-ahead read port and
// re-presents the words as a registered valid/ready stream through a 2-entry skid buffer.
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic             flush,
  output logic [CNTW-1:0]  beat_cnt
);

  logic [1:0]       cnt, cnt_nxt;
  logic [DSIZE-1:0] entry0, entry1, entry0_nxt, entry1_nxt;
  logic             valid_nxt;
  logic             pop_fifo, pop_out;

  // The pop depends only on local occupancy, never on m_ready
  assign pop_fifo = !rrst && !flush && !rempty && (cnt != 2'd2);
  assign pop_out  = m_valid && m_ready;
  assign rinc     = pop_fifo;
  assign m_data   = entry0;

  always_comb begin
    cnt_nxt    = cnt;
    entry0_nxt = entry0;
    entry1_nxt = entry1;
    if (flush) begin
      cnt_nxt = 2'd0;
    end else begin
      case ({pop_fifo, pop_out})
        2'b10: begin
          if (cnt == 2'd0) entry0_nxt = rdata;
          else             entry1_nxt = rdata;
          cnt_nxt = cnt + 2'd1;
        end
        2'b01: begin
          entry0_nxt = entry1;
          cnt_nxt    = cnt - 2'd1;
        end
        2'b11: begin
          entry0_nxt = rdata;
        end
        default: ;
      endcase
    end
    valid_nxt = (cnt_nxt != 2'd0);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      cnt     <= 2'd0;
      entry0  <= '0;
      entry1  <= '0;
      m_valid <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      entry0  <= entry0_nxt;
      entry1  <= entry1_nxt;
      m_valid <= valid_nxt;
    end
  end

  // Counts every completed transfer, including one coinciding with a flush
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst)         beat_cnt <= '0;
    else if (pop_out) beat_cnt <= beat_cnt + 1'b1;
  end

endmodule
